// File: rtl/mult_ctrl_if.sv
// Handshake and ACC strobe bundle between the multiplier controller and its datapath.
// master is the controller side; slave is the ACC/requester side.
interface mult_ctrl_if;
   logic st;
   logic m;
   logic load;
   logic ad;
   logic sh;
   logic busy;
   logic done;

   modport master (
      input  st, m,
      output load, ad, sh, busy, done
   );

   modport slave (
      output st, m,
      input  load, ad, sh, busy, done
   );
endinterface

// File: rtl/mult_ctrl.sv
// Sequencer for a shift-and-add multiplier: drives Load/Ad/Sh into the 2N+1-bit ACC
// and runs one start/done handshake per multiplication.
module mult_ctrl #(
   parameter int N = 4
) (
   input  logic        clk,
   input  logic        rst,
   mult_ctrl_if.master bus
);

   localparam int KW = $clog2(N) + 1;
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      CHECK,
      SHIFT,
      DONE
   } state_t;

   state_t        state_reg, state_next;
   logic [KW-1:0] k_reg, k_next;
   logic          load_c, ad_c, sh_c, busy_c, done_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         k_reg     <= '0;
      end else begin
         state_reg <= state_next;
         k_reg     <= k_next;
      end
   end

   // Ad/Sh in CHECK are Mealy outputs on M; every Sh advances K and the
   // N-th shift ends the operation.
   always_comb begin
      state_next = state_reg;
      k_next     = k_reg;
      load_c     = 1'b0;
      ad_c       = 1'b0;
      sh_c       = 1'b0;
      busy_c     = 1'b0;
      done_c     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.st) state_next = LOAD;
         end
         LOAD: begin
            load_c     = 1'b1;
            busy_c     = 1'b1;
            k_next     = '0;
            state_next = CHECK;
         end
         CHECK: begin
            busy_c = 1'b1;
            if (bus.m) begin
               ad_c       = 1'b1;
               state_next = SHIFT;
            end else begin
               sh_c       = 1'b1;
               k_next     = k_reg + KW'(1);
               state_next = (k_reg == K_LAST) ? DONE : CHECK;
            end
         end
         SHIFT: begin
            sh_c       = 1'b1;
            busy_c     = 1'b1;
            k_next     = k_reg + KW'(1);
            state_next = (k_reg == K_LAST) ? DONE : CHECK;
         end
         DONE: begin
            done_c = 1'b1;
            if (!bus.st) state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
            k_next     = '0;
         end
      endcase
   end

   assign bus.load = load_c;
   assign bus.ad   = ad_c;
   assign bus.sh   = sh_c;
   assign bus.busy = busy_c;
   assign bus.done = done_c;

endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl: drives it with a behavioural ACC and checks strobe sequences,
// Busy length, handshake behaviour and the final product.
module tb_mult_ctrl;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   logic [N-1:0] mplier = '0;
   logic [N-1:0] mcand  = '0;
   logic [2*N:0] acc    = '0;

   mult_ctrl_if bus();

   mult_ctrl #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // ACC datapath: load multiplier into the low half, add multiplicand into the upper half, shift right.
   assign bus.m = acc[0];
   always @(posedge clk) begin
      if (bus.load)
         acc <= {{(N+1){1'b0}}, mplier};
      else if (bus.ad)
         acc[2*N:N] <= acc[2*N:N] + {1'b0, mcand};
      else if (bus.sh)
         acc <= acc >> 1;
   end

   function automatic logic [4:0] outs();
      return {bus.load, bus.ad, bus.sh, bus.busy, bus.done};
   endfunction

   // One complete operation. st_mode: 0 drop St after start, 1 hold St, 2 random St while busy.
   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input int st_mode,
                         input int hold, input bit restart, input string name);
      int q[$];
      int expq[$];
      int busy_n, ad_n, sh_n, ovl, mi, prev, code, bad;
      bit got;
      logic [N-1:0] mseq;
      logic [2*N-1:0] prod;
      busy_n = 0; ad_n = 0; sh_n = 0; ovl = 0; mi = 0; prev = 0; got = 0; mseq = '0;
      prod = (2*N)'(a) * (2*N)'(b);
      mplier = a;
      mcand  = b;
      @(negedge clk);
      bus.st = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (bus.done) begin
            got = 1;
            break;
         end
         if (32'(bus.load) + 32'(bus.ad) + 32'(bus.sh) > 1) ovl++;
         code = bus.load ? 1 : bus.ad ? 2 : bus.sh ? 3 : 0;
         if (bus.busy) busy_n++;
         if (bus.ad) ad_n++;
         if (bus.sh) sh_n++;
         if ((bus.ad || (bus.sh && prev != 2)) && mi < N) begin
            mseq[mi] = bus.m;
            mi++;
         end
         q.push_back(code);
         prev = code;
         if (st_mode == 0) bus.st = 1'b0;
         else if (st_mode == 2) bus.st = 1'($urandom_range(0, 1));
      end
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL %s done_timeout: got done=0 after 200 cycles, want done=1", name);
         bus.st = 1'b0;
         return;
      end
      expq.push_back(1);
      for (int i = 0; i < N; i++) begin
         if (a[i]) expq.push_back(2);
         expq.push_back(3);
      end
      bad = (q.size() != expq.size()) ? 1 : 0;
      if (!bad) foreach (q[i]) if (q[i] != expq[i]) bad = 1;
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL %s strobe_seq: got %p want %p", name, q, expq);
      end
      checks++;
      if (busy_n !== 1 + N + $countones(a)) begin
         failures++;
         $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_n, 1 + N + $countones(a));
      end
      checks++;
      if (ad_n !== $countones(a) || sh_n !== N || ovl !== 0) begin
         failures++;
         $display("FAIL %s pulse_counts: got ad=%0d sh=%0d overlap=%0d want ad=%0d sh=%0d overlap=0",
                  name, ad_n, sh_n, ovl, $countones(a), N);
      end
      checks++;
      if (mseq !== a) begin
         failures++;
         $display("FAIL %s m_sequence: got %b want %b (LSB first)", name, mseq, a);
      end
      checks++;
      if (acc[2*N-1:0] !== prod || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL %s product: got acc=%0d busy=%b want %0d busy=0", name, acc[2*N-1:0], bus.busy, prod);
      end
      bus.st = (hold > 0) ? 1'b1 : 1'b0;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         checks++;
         if (bus.done !== 1'b1 || bus.load !== 1'b0 || acc[2*N-1:0] !== prod) begin
            failures++;
            $display("FAIL %s done_hold%0d: got done=%b load=%b acc=%0d want done=1 load=0 acc=%0d",
                     name, h, bus.done, bus.load, acc[2*N-1:0], prod);
         end
      end
      bus.st = 1'b0;
      @(negedge clk);
      checks++;
      if (outs() !== 5'b0) begin
         failures++;
         $display("FAIL %s back_to_idle: got outs=%b want 00000", name, outs());
      end
      if (restart) begin
         bus.st = 1'b1;
         @(negedge clk);
         checks++;
         if (bus.load !== 1'b1) begin
            failures++;
            $display("FAIL %s restart_load: got load=%b want 1", name, bus.load);
         end
         bus.st = 1'b0;
         got = 0;
         for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.done) begin
               got = 1;
               break;
            end
         end
         checks++;
         if (!got || acc[2*N-1:0] !== prod) begin
            failures++;
            $display("FAIL %s restart_product: got done=%b acc=%0d want done=1 acc=%0d", name, got, acc[2*N-1:0], prod);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      bus.st = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if (outs() !== 5'b0) begin
         failures++;
         $display("FAIL reset_async: got outs=%b want 00000", outs());
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (outs() !== 5'b0) begin
         failures++;
         $display("FAIL reset_hold: got outs=%b want 00000", outs());
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (outs() !== 5'b0) begin
         failures++;
         $display("FAIL reset_idle: got outs=%b want 00000", outs());
      end
   endtask

   task automatic test_zero();
      run_op(4'b0000, N'($urandom), 1, 3, 0, "zero");
   endtask

   task automatic test_ones();
      run_op(4'b1111, N'($urandom), 0, 0, 0, "ones");
   endtask

   task automatic test_example();
      run_op(4'b1011, 4'b1101, 0, 0, 0, "example");
      checks++;
      if (acc !== 9'b0_1000_1111) begin
         failures++;
         $display("FAIL example_acc: got %b want 010001111", acc);
      end
   endtask

   task automatic test_handshake();
      run_op(N'($urandom), N'($urandom), 1, 5, 1, "handshake");
   endtask

   task automatic test_st_ignored();
      for (int i = 0; i < 5; i++)
         run_op(N'($urandom), N'($urandom), 2, 0, 0, "st_ignored");
   endtask

   task automatic test_reset_mid();
      int n_chk, prev, code;
      bit hit;
      n_chk = 0; prev = 0; hit = 0;
      mplier = 4'b1101;
      mcand  = N'($urandom);
      @(negedge clk);
      bus.st = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         bus.st = 1'b0;
         code = bus.load ? 1 : bus.ad ? 2 : bus.sh ? 3 : 0;
         if (bus.ad || (bus.sh && prev != 2)) n_chk++;
         prev = code;
         if (n_chk == 3) begin
            hit = 1;
            break;
         end
      end
      checks++;
      if (!hit) begin
         failures++;
         $display("FAIL reset_mid_reach: got %0d CHECK cycles want 3", n_chk);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (outs() !== 5'b0) begin
         failures++;
         $display("FAIL reset_mid_async: got outs=%b want 00000", outs());
      end
      @(posedge clk);
      #1;
      checks++;
      if (outs() !== 5'b0) begin
         failures++;
         $display("FAIL reset_mid_held: got outs=%b want 00000", outs());
      end
      @(negedge clk);
      rst = 1'b0;
      run_op(N'($urandom), N'($urandom), 0, 0, 0, "after_reset");
   endtask

   task automatic test_random();
      for (int i = 0; i < 20; i++)
         run_op(N'($urandom), N'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                1'($urandom_range(0, 1)), "random");
   endtask

   initial begin
      bus.st = 1'b0;
      test_reset();
      test_zero();
      test_ones();
      test_example();
      test_handshake();
      test_st_ignored();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mult_ctrl.md
# mult_ctrl

Control unit for the shift-and-add multiplier. It sequences the 2N+1-bit ACC accumulator register through its three operations: Load, Ad (add the multiplicand into the upper half) and Sh (shift right one bit). It runs one start/done handshake per multiplication. It sits beside ACC inside the multiplier; ACC bit 0 is fed back as M.

## Interface
- N, 4: operand width in bits. Legal range 2..16. The ACC it controls is 2N+1 bits (9 for N=4).
- Clk  in  1  rising-edge clock, shared with ACC.
- Rst  in  1  asynchronous, active-high reset.
- St  in  1  start request, level-sensitive, sampled only in IDLE and DONE.
- M  in  1  current multiplier LSB, ACC[0]. Registered at the source, so there is no combinational loop.
- Load  out  1  ACC parallel-load strobe.
- Ad  out  1  ACC add strobe.
- Sh  out  1  ACC shift-right strobe.
- Busy  out  1  high from the LOAD state through the last shift.
- Done  out  1  high while in DONE.

## Operation
- States: IDLE, LOAD, CHECK, SHIFT, DONE. The encoding is free.
- Internal shift counter K:
  - Width ceil(log2(N))+1.
  - Cleared in LOAD.
  - Incremented on every cycle in which Sh=1.
- IDLE: all outputs 0. St=1 moves to LOAD; St=0 stays.
- LOAD: Load=1, Busy=1, K←0, next state CHECK.
- CHECK: Busy=1. Ad and Sh are Mealy outputs, decoded from the state and M.
  - M=1: Ad=1, next state SHIFT.
  - M=0: Sh=1, K←K+1. Next state DONE if K==N-1, else CHECK.
- SHIFT: Sh=1, Busy=1, K←K+1. Next state DONE if K==N-1, else CHECK.
- DONE: Done=1, Busy=0.
  - Stays while St=1, so a held St never retriggers.
  - Returns to IDLE when St=0.
- Load, Ad and Sh are mutually exclusive: at most one is high in any cycle.
- Exactly N Sh pulses and popcount(multiplier) Ad pulses occur per operation.
- St is ignored in LOAD, CHECK and SHIFT.
- Rst, including mid-operation, forces IDLE and K=0 immediately, asynchronously.
  - All outputs go 0 without waiting for a clock edge.
  - ACC contents are don't-care after an aborted operation.
  - The next St starts a clean operation.

## Timing
- Reset values: Load=Ad=Sh=Busy=Done=0, state IDLE, K=0.
- Edge e0 samples St=1 in IDLE. Load is high during the cycle after e0, and ACC loads at e1.
- Each multiplier bit costs 1 cycle if M=0 and 2 cycles if M=1 (Ad, then Sh).
- Busy cycles per operation = 1 + N + popcount(multiplier). Done rises on the edge after the final Sh.
- The product is valid in ACC[2N-1:0] in the first DONE cycle and stays stable while in DONE.
- Minimum restart: St low for one cycle in DONE (→IDLE), then St high (→LOAD).
- M is sampled combinationally in CHECK only. A change on M outside CHECK has no effect.

## Test plan
1. Reset mid-operation:
   - Stimulus: assert Rst in the 3rd CHECK cycle.
   - Required: all outputs 0 within the same cycle, state IDLE. A following St gives a full, correct operation.
2. Multiplier 4'b0000, N=4, bench models ACC shift of M:
   - Required: Load at cycle 1, Sh in cycles 2-5, Ad never asserted, Busy for 5 cycles.
   - Done rises at the edge after cycle 5 and holds while St=1.
3. Multiplier 4'b1111:
   - Required: Ad/Sh alternate 4 times, Busy for 9 cycles, exactly 4 Ad and 4 Sh pulses, Load/Ad/Sh never overlap.
4. Multiplier 4'b1011, multiplicand 4'b1101, with the real ACC:
   - Required: M sequence 1,1,0,1. Busy for 8 cycles. Final ACC = 9'b0_1000_1111 (143).
5. Handshake:
   - Stimulus: St held high across DONE for 5 cycles.
   - Required: no restart. St low for 1 cycle returns to IDLE with Done=0. St high again reaches Load in the next cycle.
6. St pulsed during CHECK/SHIFT:
   - Required: ignored, with no change to K, state or outputs.
